// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    id2onehot = {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/rr_arbiter8_chk.sv
// Invariant checker for rr_arbiter8 outputs; attach alongside the arbiter.
module rr_arbiter8_chk (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gnt,
  input  logic [2:0] gnt_id,
  input  logic       gnt_valid,
  input  logic       timeout
);

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  a_valid: assert property (@(posedge clk) disable iff (rst) gnt_valid == (gnt != 8'h00));

  a_id_match: assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> (gnt == (8'b1 << gnt_id)));

  a_timeout_edge: assert property (@(posedge clk) disable iff (rst)
    timeout |-> (!gnt_valid && $past(gnt_valid)));

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping mod 8.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [7:0] pick_onehot,
  output logic [2:0] pick_id,
  output logic       pick_any
);

  logic [15:0] dbl_s;
  logic [7:0]  rot_s;
  logic [2:0]  off_s;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl_s    = {req, req} >> ptr;
    rot_s    = dbl_s[7:0];
    off_s    = 3'd0;
    pick_any = |req;
    for (int i = 7; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = 3'(i);
      end else begin
        off_s = off_s;
      end
    end
    pick_id = ptr + off_s;
    if (pick_any) begin
      pick_onehot = id2onehot(pick_id);
    end else begin
      pick_onehot = 8'h00;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with registered grant, done/drop release and hold timeout.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

  arb_state_t       state_r, state_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       gnt_r, gnt_s;
  logic [2:0]       gnt_id_r, gnt_id_s;
  logic             gnt_valid_r, gnt_valid_s;
  logic             timeout_r, timeout_s;

  logic [7:0]       pick_onehot_s;
  logic [2:0]       pick_id_s;
  logic             pick_any_s;
  logic             at_limit_s;
  logic             owner_req_s;

  rr_pick8 u_pick (
    .req         (req),
    .ptr         (ptr_r),
    .pick_onehot (pick_onehot_s),
    .pick_id     (pick_id_s),
    .pick_any    (pick_any_s)
  );

  // Next-state, pointer, counter and output decode.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    gnt_s       = gnt_r;
    gnt_id_s    = gnt_id_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    at_limit_s  = (cnt_r == HOLD_MAX_C);
    owner_req_s = req[gnt_id_r];
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s     = BUSY;
          gnt_s       = pick_onehot_s;
          gnt_id_s    = pick_id_s;
          gnt_valid_s = 1'b1;
          cnt_s       = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          gnt_s       = 8'h00;
          gnt_id_s    = 3'd0;
          gnt_valid_s = 1'b0;
        end
      end
      BUSY: begin
        if (done || !owner_req_s || at_limit_s) begin
          state_s     = IDLE;
          gnt_s       = 8'h00;
          gnt_id_s    = 3'd0;
          gnt_valid_s = 1'b0;
          ptr_s       = gnt_id_r + 3'd1;
          // Forced release only when nothing else would have ended the grant.
          timeout_s   = at_limit_s && !done && owner_req_s;
        end else if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_s       = 8'h00;
        gnt_id_s    = 3'd0;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 3'd0;
      cnt_r       <= {CNT_W{1'b0}};
      gnt_r       <= 8'h00;
      gnt_id_r    <= 3'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
      gnt_r       <= gnt_s;
      gnt_id_r    <= gnt_id_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed-vector bench for rr_arbiter8 with HOLD_MAX=4.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  rr_arbiter8_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all four outputs against one expected vector.
  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                            input logic v, input logic t);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".id"}, 32'(gnt_id), 32'(id));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    // Reset with everyone requesting.
    step();
    step();
    expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    expect_out("drop0", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single requester 5, done after three grant cycles, then re-grant via wrap.
    req = 8'h20;
    step();
    expect_out("single_c1", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    expect_out("single_c2", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    expect_out("single_c3", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    step();
    expect_out("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("single_regrant", 8'h20, 3'd5, 1'b1, 1'b0);

    // Fairness sweep from ptr=0 with all requesting.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      check("rr_valid", 32'(gnt_valid), 32'd1);
      check("rr_id", 32'(gnt_id), 32'(k % 8));
      check("rr_gnt", 32'(gnt), 32'(8'h01 << (k % 8)));
      done = 1'b1;
      step();
      check("rr_gap", 32'(gnt_valid), 32'd0);
      done = 1'b0;
    end
    req = 8'h00;

    // Hold timeout on requester 3 (ptr=1 after the sweep).
    step();
    req = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      step();
      expect_out("hold", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step();
    expect_out("timeout_rel", 8'h00, 3'd0, 1'b0, 1'b1);
    req = 8'h09;
    step();
    expect_out("after_timeout", 8'h01, 3'd0, 1'b1, 1'b0);

    // Owner drops its request; ptr moves to 3 so 7 beats 0.
    req = 8'h00;
    step();
    check("drop_idle", 32'(gnt_valid), 32'd0);
    req = 8'h04;
    step();
    expect_out("drop_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h81;
    step();
    expect_out("drop_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    expect_out("drop_grant7", 8'h80, 3'd7, 1'b1, 1'b0);

    // Mid-grant reset restores ptr=0.
    req = 8'h00;
    step();
    req = 8'h40;
    step();
    expect_out("mid_grant", 8'h40, 3'd6, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    expect_out("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 8'hFF;
    step();
    expect_out("post_reset", 8'h01, 3'd0, 1'b1, 1'b0);

    // done coincides with counter==HOLD_MAX: plain release, no timeout.
    step();
    step();
    step();
    expect_out("coinc_c4", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    expect_out("coinc_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("coinc_next", 8'h02, 3'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
